// File: rtl/ifu_axil_reader_if.sv
// AXI-Lite bus bundle used by the instruction fetch reader.
// The master modport drives AR/R handshakes; the write channel exists only to be tied off.
interface axil_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ifu_axil_reader.sv
// Single-outstanding AXI-Lite read master for instruction fetch, with flush/drain.
// Optional: define IFU_ERR_TRAP_EN to substitute EBREAK for words returned with an error response.
module ifu_axil_reader #(
  parameter int DATA_W = 32
`ifdef IFU_ERR_TRAP_EN
  , parameter bit ENDIANESS = 1'b0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] addr,
  input  logic              rd,
  input  logic              valid,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [31:0]       fetch_count,
  axil_if.master            axil_bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t            state, state_nx;
  logic              kill;
  logic [DATA_W-1:0] araddr_q;
  logic [DATA_W-1:0] rdata_eff;
  logic              req;
  logic              accept;
  logic              deliver;

  assign req     = rd & valid;
  // The done cycle never accepts: fetch moves its pc on that same edge.
  assign accept  = (state == IDLE) & req & ~flush & ~done;
  assign deliver = (state == DATA) & axil_bus.rvalid & ~flush;

`ifdef IFU_ERR_TRAP_EN
  localparam logic [DATA_W-1:0] EBREAK = ENDIANESS ? DATA_W'(32'h7300_1000)
                                                   : DATA_W'(32'h0010_0073);
  assign rdata_eff = (axil_bus.rresp != 2'b00) ? EBREAK : axil_bus.rdata;
`else
  assign rdata_eff = axil_bus.rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = ADDR;
      // A flush in ADDR cannot retract arvalid; remember it and drain instead.
      ADDR:  if (axil_bus.arready) state_nx = (kill | flush) ? DRAIN : DATA;
      DATA:  begin
        if (axil_bus.rvalid) state_nx = IDLE;
        else if (flush)      state_nx = DRAIN;
      end
      DRAIN: if (axil_bus.rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    axil_bus.arvalid = (state == ADDR);
    axil_bus.rready  = (state == DATA) | (state == DRAIN);
    axil_bus.araddr  = araddr_q;
    axil_bus.arprot  = 3'b100;
    axil_bus.awvalid = 1'b0;
    axil_bus.awaddr  = '0;
    axil_bus.awprot  = 3'b000;
    axil_bus.wvalid  = 1'b0;
    axil_bus.wdata   = '0;
    axil_bus.wstrb   = '0;
    axil_bus.bready  = 1'b0;
    busy             = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q    <= '0;
      kill        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      data_out    <= '0;
      fetch_count <= '0;
    end else begin
      if (accept) araddr_q <= addr & ~DATA_W'(3);
      if (state_nx == IDLE)                 kill <= 1'b0;
      else if ((state == ADDR) && flush)    kill <= 1'b1;
      done <= deliver;
      if (deliver) begin
        data_out    <= rdata_eff;
        err         <= (axil_bus.rresp != 2'b00);
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
